// File: rtl/cphy_tx_defs.sv
// ----------------------------------------------------------------------------
// cphy_tx_defs
// Shared definitions for the C-PHY HS transmit path.
//   - tx_state_e : burst sequencer state encoding
//   - hs_word_t  : one 7-symbol word as {flip, rot, pol}; bit i is symbol i,
//                  and symbol 0 goes out first
//   - SYM3/SYM4  : 3-bit {F,R,P} symbol codes
//   - WORD_PRE / WORD_SYNC / WORD_POST : fixed burst words
// ----------------------------------------------------------------------------
package cphy_tx_defs;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREP     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_SYNC     = 3'd3,
        ST_DATA     = 3'd4,
        ST_POST     = 3'd5,
        ST_GAP      = 3'd6
    } tx_state_e;

    typedef struct packed {
        logic [6:0] flip;
        logic [6:0] rot;
        logic [6:0] pol;
    } hs_word_t;

    localparam logic [2:0] SYM3 = 3'b011;
    localparam logic [2:0] SYM4 = 3'b100;

    // Word carrying the same symbol in all seven positions.
    function automatic hs_word_t fill_word(input logic [2:0] sym);
        hs_word_t w;
        w.flip = {7{sym[2]}};
        w.rot  = {7{sym[1]}};
        w.pol  = {7{sym[0]}};
        return w;
    endfunction

    localparam hs_word_t WORD_PRE  = fill_word(SYM3);
    // Symbol sequence 3444443, symbol 0 in bit 0.
    localparam hs_word_t WORD_SYNC = hs_word_t'({7'b0111110, 7'b1000001, 7'b1000001});
    localparam hs_word_t WORD_POST = fill_word(SYM4);

endpackage

// File: rtl/hs_tx_sequencer.sv
// ----------------------------------------------------------------------------
// hs_tx_sequencer
// Sequences one C-PHY HS burst toward the serializer:
//   PREP wait -> preamble words -> sync word -> payload words -> post words,
// followed by an idle gap before another request is accepted. One 7-symbol
// word is presented per TxWordClkHs cycle.
//
// Ports
//   TxWordClkHs   in   word clock, rising edge
//   rst           in   asynchronous active-low reset
//   TxRequestHS   in   PPI HS request, held high for the burst
//   CfgPreWords   in   preamble length in words (0 behaves as 1), latched at burst start
//   DataFlip/Rot/Pol in mapped payload word
//   TxReadyHS     out  payload word accepted on an edge where TxRequestHS & TxReadyHS
//   SerializerEn  out  serializer enable (registered)
//   TxFlip/TxRotation/TxPolarity out word to the serializer (registered)
//   HsActive      out  high from PREP through POST
//   BurstDone     out  one-cycle pulse on the POST->GAP edge (registered)
//   dbg_state     out  current sequencer state, for observation only
//
// Handshake: TxReadyHS is high in SYNC and DATA. On every edge where both
// TxRequestHS and TxReadyHS are high, Data* is captured into the output word.
// TxRequestHS low while TxReadyHS is high ends the payload and starts POST.
// ----------------------------------------------------------------------------
module hs_tx_sequencer
    import cphy_tx_defs::*;
#(
    parameter int PREP_CYCLES = 2,
    parameter int POST_WORDS  = 1,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       TxWordClkHs,
    input  logic       rst,
    input  logic       TxRequestHS,
    input  logic [7:0] CfgPreWords,
    input  logic [6:0] DataFlip,
    input  logic [6:0] DataRot,
    input  logic [6:0] DataPol,
    output logic       TxReadyHS,
    output logic       SerializerEn,
    output logic [6:0] TxFlip,
    output logic [6:0] TxRotation,
    output logic [6:0] TxPolarity,
    output logic       HsActive,
    output logic       BurstDone,
    output logic [2:0] dbg_state
);

    localparam logic [7:0] PREP_LOAD = 8'(PREP_CYCLES - 1);
    localparam logic [7:0] POST_LOAD = 8'(POST_WORDS - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    tx_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] pre_q, pre_d;
    hs_word_t   word_q, word_d;
    logic       ser_en_q, ser_en_d;
    logic       burst_done_q, burst_done_d;

    hs_word_t   data_word;
    assign data_word = '{flip: DataFlip, rot: DataRot, pol: DataPol};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pre_d        = pre_q;
        word_d       = word_q;
        ser_en_d     = ser_en_q;
        burst_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (TxRequestHS) begin
                    state_d = ST_PREP;
                    cnt_d   = PREP_LOAD;
                    // A zero-length preamble is not legal on the line.
                    pre_d   = (CfgPreWords == 8'd0) ? 8'd1 : CfgPreWords;
                end
            end

            ST_PREP: begin
                word_d   = '0;
                ser_en_d = 1'b0;
                if (cnt_q == 8'd0) begin
                    state_d  = ST_PREAMBLE;
                    cnt_d    = pre_q - 8'd1;
                    word_d   = WORD_PRE;
                    ser_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_PREAMBLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SYNC;
                    word_d  = WORD_SYNC;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            // The request is sampled even in SYNC, so a request dropped
            // before the payload still yields a clean SYNC -> POST burst.
            ST_SYNC, ST_DATA: begin
                if (TxRequestHS) begin
                    state_d = ST_DATA;
                    word_d  = data_word;
                end else begin
                    state_d = ST_POST;
                    word_d  = WORD_POST;
                    cnt_d   = POST_LOAD;
                end
            end

            ST_POST: begin
                if (cnt_q == 8'd0) begin
                    state_d      = ST_GAP;
                    word_d       = '0;
                    ser_en_d     = 1'b0;
                    burst_done_d = 1'b1;
                    cnt_d        = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = 8'd0;
                word_d   = '0;
                ser_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge TxWordClkHs or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            pre_q        <= 8'd0;
            word_q       <= '0;
            ser_en_q     <= 1'b0;
            burst_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pre_q        <= pre_d;
            word_q       <= word_d;
            ser_en_q     <= ser_en_d;
            burst_done_q <= burst_done_d;
        end
    end

    assign TxReadyHS    = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign HsActive     = (state_q == ST_PREP) || (state_q == ST_PREAMBLE) ||
                          (state_q == ST_SYNC) || (state_q == ST_DATA) ||
                          (state_q == ST_POST);
    assign SerializerEn = ser_en_q;
    assign TxFlip       = word_q.flip;
    assign TxRotation   = word_q.rot;
    assign TxPolarity   = word_q.pol;
    assign BurstDone    = burst_done_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_hs_tx_sequencer.sv
// ----------------------------------------------------------------------------
// tb_hs_tx_sequencer
// Directed bench for hs_tx_sequencer with default parameters
// (PREP_CYCLES=2, POST_WORDS=1, GAP_CYCLES=2). Words are handled as
// {flip[20:14], rot[13:7], pol[6:0]}.
// ----------------------------------------------------------------------------
module tb_hs_tx_sequencer;

  logic       clk;
  logic       rst;
  logic       tx_request_hs;
  logic [7:0] cfg_pre_words;
  logic [6:0] data_flip;
  logic [6:0] data_rot;
  logic [6:0] data_pol;
  logic       tx_ready_hs;
  logic       serializer_en;
  logic [6:0] tx_flip;
  logic [6:0] tx_rotation;
  logic [6:0] tx_polarity;
  logic       hs_active;
  logic       burst_done;
  logic [2:0] dbg_state;

  hs_tx_sequencer #(
    .PREP_CYCLES(2),
    .POST_WORDS (1),
    .GAP_CYCLES (2)
  ) dut (
    .TxWordClkHs (clk),
    .rst         (rst),
    .TxRequestHS (tx_request_hs),
    .CfgPreWords (cfg_pre_words),
    .DataFlip    (data_flip),
    .DataRot     (data_rot),
    .DataPol     (data_pol),
    .TxReadyHS   (tx_ready_hs),
    .SerializerEn(serializer_en),
    .TxFlip      (tx_flip),
    .TxRotation  (tx_rotation),
    .TxPolarity  (tx_polarity),
    .HsActive    (hs_active),
    .BurstDone   (burst_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- constants and state ----------------
  localparam logic [20:0] W_PRE  = {7'h00, 7'h7F, 7'h7F};
  localparam logic [20:0] W_SYNC = {7'b0111110, 7'b1000001, 7'b1000001};
  localparam logic [20:0] W_POST = {7'h7F, 7'h00, 7'h00};

  int checks;
  int errors;

  logic [2:0]  d_syms [4][7];
  logic [20:0] d_words [4];

  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  logic [20:0] full_obs_q[$];

  int prep_cnt;
  int done_cnt;
  int ready_cnt;
  int en_rises;
  int bad_idle_words;
  bit timed_out;

  function automatic logic [20:0] cur_word();
    return {tx_flip, tx_rotation, tx_polarity};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Runs one burst: request high, payload words fed on the ready handshake,
  // request dropped after n_data accepts (or in PREP if drop_early).
  // Records the enabled word stream and burst statistics.
  task automatic run_burst(input logic [7:0] cfg, input int n_data, input bit drop_early);
    int  accepted;
    int  cyc;
    int  idle_after;
    bit  seen_done;
    bit  take;
    logic prev_en;
    accepted = 0; cyc = 0; idle_after = 0; seen_done = 0;
    obs_q.delete();
    prep_cnt = 0; done_cnt = 0; ready_cnt = 0; en_rises = 0;
    bad_idle_words = 0; timed_out = 0;
    prev_en = serializer_en;
    cfg_pre_words = cfg;
    tx_request_hs = 1'b1;
    {data_flip, data_rot, data_pol} = (n_data > 0) ? d_words[0] : 21'h0;
    while (!(seen_done && idle_after >= 3)) begin
      take = tx_request_hs && tx_ready_hs;
      tick();
      cyc++;
      if (take) accepted++;
      if (serializer_en) obs_q.push_back(cur_word());
      else if (cur_word() != 21'h0) bad_idle_words++;
      if (serializer_en && !prev_en) en_rises++;
      prev_en = serializer_en;
      if (hs_active && !serializer_en && obs_q.size() == 0) prep_cnt++;
      if (tx_ready_hs) ready_cnt++;
      if (burst_done) begin
        done_cnt++;
        seen_done = 1;
      end else if (seen_done) begin
        idle_after++;
      end
      if (drop_early && hs_active) tx_request_hs = 1'b0;
      if (!drop_early && accepted >= n_data && tx_ready_hs) tx_request_hs = 1'b0;
      if (accepted < n_data) {data_flip, data_rot, data_pol} = d_words[accepted];
      if (cyc > 200) begin
        timed_out = 1;
        break;
      end
    end
    tx_request_hs = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    tx_request_hs = 1'b1;
    cfg_pre_words = 8'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({serializer_en, hs_active, tx_ready_hs, burst_done, cur_word()} !== 25'h0 ||
          dbg_state !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: en=%b act=%b rdy=%b done=%b word=%h st=%0d required all 0",
                 i, serializer_en, hs_active, tx_ready_hs, burst_done, cur_word(), dbg_state);
      end
    end
    tx_request_hs = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({serializer_en, hs_active, tx_ready_hs, burst_done, cur_word()} !== 25'h0) begin
        errors++;
        $display("FAIL idle_after_reset cyc%0d: en=%b act=%b rdy=%b done=%b word=%h required all 0",
                 i, serializer_en, hs_active, tx_ready_hs, burst_done, cur_word());
      end
    end
  endtask

  task automatic test_full_burst();
    run_burst(8'd3, 4, 0);
    exp_q.delete();
    exp_q.push_back(W_PRE); exp_q.push_back(W_PRE); exp_q.push_back(W_PRE);
    exp_q.push_back(W_SYNC);
    for (int k = 0; k < 4; k++) exp_q.push_back(d_words[k]);
    exp_q.push_back(W_POST);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout: burst did not complete"); end
    checks++;
    if (prep_cnt !== 2) begin errors++; $display("FAIL full_prep_cycles: got %0d required 2", prep_cnt); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL full_word_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (en_rises !== 1) begin errors++; $display("FAIL full_en_continuous: rises %0d required 1", en_rises); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL full_burst_done: pulses %0d required 1", done_cnt); end
    checks++;
    if (ready_cnt !== 5) begin errors++; $display("FAIL full_ready_cycles: got %0d required 5", ready_cnt); end
    checks++;
    if (bad_idle_words !== 0) begin errors++; $display("FAIL full_idle_word: %0d nonzero words with en=0, required 0", bad_idle_words); end
    full_obs_q = obs_q;
  endtask

  task automatic test_symbol_stream();
    logic [2:0] exp_sym[$];
    logic [2:0] obs_sym[$];
    logic [20:0] w;
    for (int i = 0; i < 21; i++) exp_sym.push_back(3'b011);
    exp_sym.push_back(3'b011);
    for (int i = 0; i < 5; i++) exp_sym.push_back(3'b100);
    exp_sym.push_back(3'b011);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 7; i++) exp_sym.push_back(d_syms[k][i]);
    for (int i = 0; i < 7; i++) exp_sym.push_back(3'b100);
    for (int j = 0; j < full_obs_q.size(); j++) begin
      w = full_obs_q[j];
      for (int i = 0; i < 7; i++) obs_sym.push_back({w[14+i], w[7+i], w[i]});
    end
    checks++;
    if (obs_sym.size() !== exp_sym.size()) begin
      errors++;
      $display("FAIL sym_count: got %0d required %0d", obs_sym.size(), exp_sym.size());
    end
    for (int i = 0; i < exp_sym.size() && i < obs_sym.size(); i++) begin
      checks++;
      if (obs_sym[i] !== exp_sym[i]) begin
        errors++;
        $display("FAIL sym%0d: got %0d required %0d", i, obs_sym[i], exp_sym[i]);
      end
    end
  endtask

  task automatic test_zero_pre_drop_early();
    run_burst(8'd0, 0, 1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL drop_timeout: burst did not complete"); end
    checks++;
    if (obs_q.size() !== 3) begin
      errors++;
      $display("FAIL drop_word_count: got %0d required 3", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== W_PRE || obs_q[1] !== W_SYNC || obs_q[2] !== W_POST) begin
        errors++;
        $display("FAIL drop_words: got %h %h %h required %h %h %h",
                 obs_q[0], obs_q[1], obs_q[2], W_PRE, W_SYNC, W_POST);
      end
    end
    checks++;
    if (ready_cnt !== 1) begin errors++; $display("FAIL drop_ready_cycles: got %0d required 1", ready_cnt); end
    checks++;
    if (prep_cnt !== 2) begin errors++; $display("FAIL drop_prep_cycles: got %0d required 2", prep_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL drop_burst_done: pulses %0d required 1", done_cnt); end
  endtask

  task automatic test_gap_rerequest();
    int cyc;
    cfg_pre_words = 8'd1;
    tx_request_hs = 1'b1;
    cyc = 0;
    // zero-payload burst: drop in PREP, wait for BurstDone
    do begin
      tick();
      cyc++;
      if (hs_active) tx_request_hs = 1'b0;
    end while (!burst_done && cyc < 100);
    checks++;
    if (!burst_done) begin errors++; $display("FAIL gap_done_timeout: BurstDone not seen"); end
    tick();  // first cycle after BurstDone: raise the new request
    tx_request_hs = 1'b1;
    checks++;
    if (burst_done !== 1'b0 || hs_active !== 1'b0) begin
      errors++;
      $display("FAIL gap_cyc1: done=%b act=%b required 0 0", burst_done, hs_active);
    end
    tick();
    checks++;
    if (hs_active !== 1'b0) begin errors++; $display("FAIL gap_cyc2: act=%b required 0", hs_active); end
    tick();
    checks++;
    if (hs_active !== 1'b1 || serializer_en !== 1'b0 || cur_word() !== 21'h0) begin
      errors++;
      $display("FAIL gap_prep_start: act=%b en=%b word=%h required 1 0 0", hs_active, serializer_en, cur_word());
    end
    tx_request_hs = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (!burst_done && cyc < 100);
    checks++;
    if (!burst_done) begin errors++; $display("FAIL gap_second_done: BurstDone not seen"); end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_burst();
    int  accepted;
    int  cyc;
    bit  take;
    accepted = 0; cyc = 0;
    cfg_pre_words = 8'd1;
    tx_request_hs = 1'b1;
    {data_flip, data_rot, data_pol} = d_words[0];
    while (!(tx_ready_hs && cur_word() === d_words[1]) && cyc < 100) begin
      take = tx_request_hs && tx_ready_hs;
      tick();
      cyc++;
      if (take) accepted++;
      if (accepted < 4) {data_flip, data_rot, data_pol} = d_words[accepted];
    end
    checks++;
    if (cyc >= 100) begin errors++; $display("FAIL rst_mid_timeout: D1 never on bus"); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({serializer_en, hs_active, tx_ready_hs, burst_done, cur_word()} !== 25'h0 ||
        dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_async: en=%b act=%b rdy=%b done=%b word=%h st=%0d required all 0",
               serializer_en, hs_active, tx_ready_hs, burst_done, cur_word(), dbg_state);
    end
    tx_request_hs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (serializer_en !== 1'b0 || cur_word() !== 21'h0) begin
        errors++;
        $display("FAIL rst_mid_no_post cyc%0d: en=%b word=%h required 0 0", i, serializer_en, cur_word());
      end
    end
    #3 rst = 1'b1;
    tick();
    run_burst(8'd3, 4, 0);
    checks++;
    if (timed_out || prep_cnt !== 2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL rst_fresh_stats: timeout=%0d prep=%0d done=%0d required 0 2 1", timed_out, prep_cnt, done_cnt);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rst_fresh_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_fresh_word%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    tx_request_hs = 1'b0;
    cfg_pre_words = 8'd0;
    data_flip = '0; data_rot = '0; data_pol = '0;

    d_syms[0][0] = 3'd0; d_syms[0][1] = 3'd1; d_syms[0][2] = 3'd2; d_syms[0][3] = 3'd3;
    d_syms[0][4] = 3'd4; d_syms[0][5] = 3'd0; d_syms[0][6] = 3'd1;
    d_syms[1][0] = 3'd4; d_syms[1][1] = 3'd4; d_syms[1][2] = 3'd3; d_syms[1][3] = 3'd3;
    d_syms[1][4] = 3'd2; d_syms[1][5] = 3'd1; d_syms[1][6] = 3'd0;
    d_syms[2][0] = 3'd1; d_syms[2][1] = 3'd3; d_syms[2][2] = 3'd0; d_syms[2][3] = 3'd2;
    d_syms[2][4] = 3'd4; d_syms[2][5] = 3'd1; d_syms[2][6] = 3'd3;
    d_syms[3][0] = 3'd2; d_syms[3][1] = 3'd2; d_syms[3][2] = 3'd2; d_syms[3][3] = 3'd0;
    d_syms[3][4] = 3'd0; d_syms[3][5] = 3'd4; d_syms[3][6] = 3'd4;
    for (int k = 0; k < 4; k++) begin
      d_words[k] = 21'h0;
      for (int i = 0; i < 7; i++) begin
        d_words[k][14+i] = d_syms[k][i][2];
        d_words[k][7+i]  = d_syms[k][i][1];
        d_words[k][i]    = d_syms[k][i][0];
      end
    end

    test_reset();
    test_full_burst();
    test_symbol_stream();
    test_zero_pre_drop_early();
    test_gap_rerequest();
    test_reset_mid_burst();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
